// File: rtl/edge_det_multi.sv
// Multi-channel edge detector: per-channel synchroniser, mode-selected edge pulse, sticky W1C pending flag
// and saturating event counter. Define EDGE_DEBOUNCE_EN to add a per-channel stability filter.
module edge_det_multi #(
  parameter int CH        = 4,
  parameter int SYNC      = 2,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         d_in,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr,
  input  logic                  cnt_clr,
  output logic [CH-1:0]         d_out,
  output logic [CH-1:0]         pend,
  output logic                  any_pend,
  output logic [CH*CNT_W-1:0]   cnt
);

`ifdef EDGE_DEBOUNCE_EN
  localparam int W = SYNC + DB_CYCLES + 1;
`else
  // DB_CYCLES has no effect without the filter.
  localparam int W = SYNC + 1 + 0 * DB_CYCLES;
`endif
  localparam int WARM_W = $clog2(W + 1);

  logic [CH-1:0]     r_sync [SYNC];
  logic [CH-1:0]     r_prev;
  logic [CH-1:0]     r_dout;
  logic [CH-1:0]     r_pend;
  logic [CNT_W-1:0]  r_cnt [CH];
  logic [WARM_W-1:0] r_warm;

  logic [CH-1:0]     w_s;
  logic [CH-1:0]     w_filt;
  logic [CH-1:0]     w_edge;
  logic              w_warm_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= d_in;
      for (int k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0] r_db [CH];
  logic [CH-1:0]   r_filt;

  // f follows s only after s has differed from f for DB_CYCLES consecutive clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < CH; i++) r_db[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_s[i] == r_filt[i]) begin
          r_db[i] <= '0;
        end else if (r_db[i] == DB_W'(DB_CYCLES - 1)) begin
          r_filt[i] <= w_s[i];
          r_db[i]   <= '0;
        end else begin
          r_db[i] <= r_db[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = w_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= '0;
    end else if (r_warm != WARM_W'(W)) begin
      r_warm <= r_warm + WARM_W'(1);
    end
  end

  // Masks the edge the pipeline would otherwise see while it fills with the post-reset level.
  assign w_warm_done = (r_warm == WARM_W'(W));

  always_comb begin
    w_edge = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        2'b01:   w_edge[i] = w_filt[i] & ~r_prev[i];
        2'b10:   w_edge[i] = ~w_filt[i] & r_prev[i];
        2'b11:   w_edge[i] = w_filt[i] ^ r_prev[i];
        default: w_edge[i] = 1'b0;
      endcase
    end
    if (!w_warm_done) w_edge = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_dout <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= w_filt;
      r_dout <= w_edge;
      r_pend <= w_edge | (r_pend & ~clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cnt_clr) begin
          r_cnt[i] <= w_edge[i] ? CNT_W'(1) : '0;
        end else if (w_edge[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign d_out    = r_dout;
  assign pend     = r_pend;
  assign any_pend = |r_pend;

endmodule

// File: tb/tb_edge_det_multi.sv
// Directed bench for edge_det_multi (CH=4, SYNC=2, CNT_W=4); latency expectations follow EDGE_DEBOUNCE_EN.
module tb_edge_det_multi;

  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int DB    = 3;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DB;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [CH-1:0]       d_in = '0;
  logic [2*CH-1:0]     mode = '0;
  logic [CH-1:0]       clr = '0;
  logic                cnt_clr = 1'b0;
  logic [CH-1:0]       d_out;
  logic [CH-1:0]       pend;
  logic                any_pend;
  logic [CH*CNT_W-1:0] cnt;

  int total = 0;
  int bad   = 0;

  edge_det_multi #(.CH(CH), .SYNC(SYNC), .CNT_W(CNT_W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
    .d_out(d_out), .pend(pend), .any_pend(any_pend), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int ones2;
    int first;

    // reset with inputs held high, both-edge mode everywhere
    d_in = 4'hF;
    mode = 8'hFF;
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_dout", 32'(d_out), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    ones = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      ones += int'(d_out != '0);
    end
    chk("warm_no_pulse", 32'(ones), 32'd0);
    chk("warm_pend", 32'(pend), 32'h0);
    chk("warm_cnt", 32'(cnt), 32'h0);
    chk("warm_any", 32'(any_pend), 32'h0);

    // drop all inputs with every channel off: nothing may register
    mode = 8'h00;
    d_in = 4'h0;
    repeat (6) tick();
    chk("off_pend", 32'(pend), 32'h0);
    chk("off_cnt", 32'(cnt), 32'h0);

    // ch0 rise
    mode = 8'b01_00_11_01;
    d_in[0] = 1'b1;
    repeat (LAT - 1) tick();
    chk("rise_early", 32'(d_out), 32'h0);
    tick();
    chk("rise_pulse", 32'(d_out), 32'h1);
    tick();
    chk("rise_one_cycle", 32'(d_out), 32'h0);
    chk("rise_pend", 32'(pend), 32'h1);
    chk("rise_cnt0", 32'(cnt[3:0]), 32'd1);
    chk("rise_any", 32'(any_pend), 32'h1);
    d_in[0] = 1'b0;
    ones = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      ones += int'(d_out[0]);
    end
    chk("fall_ignored", 32'(ones), 32'd0);
    chk("fall_cnt0", 32'(cnt[3:0]), 32'd1);

    // ch1 both-edge vs ch2 off with identical stimulus
    d_in[0] = 1'b1;
    repeat (LAT + 2) tick();
    d_in[2:1] = 2'b11;
    ones = 0;
    ones2 = 0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      ones  += int'(d_out[1]);
      ones2 += int'(d_out[2]);
      if (j == 3) d_in[2:1] = 2'b00;
    end
    chk("both_pulses", 32'(ones), 32'd2);
    chk("both_cnt1", 32'(cnt[7:4]), 32'd2);
    chk("both_pend1", 32'(pend[1]), 32'h1);
    chk("off_pulses", 32'(ones2), 32'd0);
    chk("off_pend2", 32'(pend[2]), 32'h0);
    chk("off_cnt2", 32'(cnt[11:8]), 32'd0);

    // W1C on pend
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("clr0_pend", 32'(pend), 32'h2);
    chk("clr0_any", 32'(any_pend), 32'h1);
    clr = 4'b0010;
    tick();
    clr = 4'b0000;
    chk("clr1_pend", 32'(pend), 32'h0);
    chk("clr1_any", 32'(any_pend), 32'h0);

    // set wins over clear in the same cycle
    d_in[0] = 1'b0;
    repeat (LAT + 2) tick();
    d_in[0] = 1'b1;
    repeat (LAT - 1) tick();
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("setwin_dout", 32'(d_out), 32'h1);
    chk("setwin_pend", 32'(pend), 32'h1);
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("clr_alone_pend", 32'(pend), 32'h0);
    chk("clr_alone_any", 32'(any_pend), 32'h0);

    // ch3 counter saturation
    for (int k = 0; k < 10; k++) begin
      d_in[3] = 1'b1;
      repeat (4) tick();
      d_in[3] = 1'b0;
      repeat (4) tick();
    end
    repeat (LAT) tick();
    chk("cnt3_ten", 32'(cnt[15:12]), 32'd10);
    for (int k = 0; k < 10; k++) begin
      d_in[3] = 1'b1;
      repeat (4) tick();
      d_in[3] = 1'b0;
      repeat (4) tick();
    end
    repeat (LAT) tick();
    chk("cnt3_sat", 32'(cnt[15:12]), 32'd15);

    // cnt_clr coincident with an edge, then alone
    d_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cntclr_edge", 32'(cnt), 32'h1000);
    d_in[3] = 1'b0;
    repeat (LAT + 2) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cntclr_alone", 32'(cnt), 32'h0);

    // reset while a pulse is in flight
    d_in[0] = 1'b0;
    repeat (LAT + 2) tick();
    d_in[0] = 1'b1;
    repeat (LAT) tick();
    chk("inflight_dout", 32'(d_out[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_dout", 32'(d_out), 32'h0);
    chk("midrst_pend", 32'(pend), 32'h0);
    chk("midrst_cnt", 32'(cnt), 32'h0);
    chk("midrst_any", 32'(any_pend), 32'h0);
    d_in = 4'hF;
    mode = 8'hFF;
    repeat (2) tick();
    rst = 1'b0;
    ones = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      ones += int'(d_out != '0);
    end
    chk("rewarm_no_pulse", 32'(ones), 32'd0);
    chk("rewarm_pend", 32'(pend), 32'h0);

    // rise latency on ch0, and glitch rejection when filtered
    mode = 8'b00_00_00_01;
    d_in = 4'h0;
    repeat (LAT + 4) tick();
`ifdef EDGE_DEBOUNCE_EN
    d_in[0] = 1'b1;
    repeat (2) tick();
    d_in[0] = 1'b0;
    ones = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      ones += int'(d_out[0]);
    end
    chk("glitch_rejected", 32'(ones), 32'd0);
    chk("glitch_pend", 32'(pend[0]), 32'h0);
`endif
    d_in[0] = 1'b1;
    ones  = 0;
    first = 0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (j == 5) d_in[0] = 1'b0;
      if (d_out[0] && first == 0) first = j;
      ones += int'(d_out[0]);
    end
    chk("latency", 32'(first), 32'(LAT));
    chk("latency_single", 32'(ones), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
